// File: rtl/llc_req_arbiter_pkg.sv
// Shared types and helpers for the LLC request arbiter.
// Command codes, FSM encoding and per-port legality checks.
package llc_req_arbiter_pkg;

    localparam int CMDSIZE   = 4;
    localparam int ADDR_BITS = 32;

    typedef logic [CMDSIZE-1:0] cmd_bits_t;

    typedef enum logic [CMDSIZE-1:0] {
        RD_L1D   = 4'd0,
        WR_L1D   = 4'd1,
        RD_L1I   = 4'd2,
        SNP_INV  = 4'd3,
        SNP_RD   = 4'd4,
        SNP_WR   = 4'd5,
        SNP_RWIM = 4'd6,
        CLR      = 4'd8,
        PRINT    = 4'd9
    } cmd_t;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_ISSUE = 2'd1;
    localparam arb_state_t ST_WAIT  = 2'd2;
    localparam arb_state_t ST_LOCAL = 2'd3;

    function automatic logic is_l1_cmd(cmd_bits_t c);
        case (c)
            RD_L1D, WR_L1D, RD_L1I, CLR, PRINT: is_l1_cmd = 1'b1;
            default:                            is_l1_cmd = 1'b0;
        endcase
    endfunction

    function automatic logic is_snp_cmd(cmd_bits_t c);
        case (c)
            SNP_INV, SNP_RD, SNP_WR, SNP_RWIM: is_snp_cmd = 1'b1;
            default:                           is_snp_cmd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/llc_arb_pick.sv
// Combinational winner selection between snoop and L1 requests,
// plus the next value of the snoop streak counter.
module llc_arb_pick #(
    parameter int MAX_SNOOP_STREAK = 4,
    parameter int SW               = 3
) (
    input  logic          en,
    input  logic          l1_valid,
    input  logic          snp_valid,
    input  logic [SW-1:0] streak,
    output logic          grant_l1,
    output logic          grant_snp,
    output logic [SW-1:0] streak_nxt
);

    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_SNOOP_STREAK);

    logic l1_starved;

    // Snoops win unless L1 has already waited out a full streak.
    assign l1_starved = l1_valid && (streak == STREAK_MAX);
    assign grant_snp  = en && snp_valid && !l1_starved;
    assign grant_l1   = en && l1_valid && !grant_snp;

    always_comb begin
        streak_nxt = streak;
        unique case (1'b1)
            grant_snp && l1_valid:
                streak_nxt = (streak == STREAK_MAX) ? streak : streak + SW'(1);
            grant_snp && !l1_valid:
                streak_nxt = '0;
            grant_l1:
                streak_nxt = '0;
            default: ;
        endcase
    end

endmodule

// File: rtl/llc_req_arbiter.sv
// Serializes L1 and snoop requests into a single LLC command stream.
// Define LLC_ARB_STATS_EN to add saturating grant/error counters.
module llc_req_arbiter #(
    parameter int CMDSIZE          = llc_req_arbiter_pkg::CMDSIZE,
    parameter int ADDR_BITS        = llc_req_arbiter_pkg::ADDR_BITS,
    parameter int MAX_SNOOP_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 l1_valid,
    input  logic [CMDSIZE-1:0]   l1_cmd,
    input  logic [ADDR_BITS-1:0] l1_addr,
    output logic                 l1_ready,
    output logic                 l1_done,
    input  logic                 snp_valid,
    input  logic [CMDSIZE-1:0]   snp_cmd,
    input  logic [ADDR_BITS-1:0] snp_addr,
    output logic                 snp_ready,
    output logic                 snp_done,
    output logic                 llc_valid,
    output logic [CMDSIZE-1:0]   llc_cmd,
    output logic [ADDR_BITS-1:0] llc_addr,
    output logic                 llc_src,
    input  logic                 llc_ready,
    input  logic                 llc_done,
    output logic                 busy,
    output logic                 cmd_err
`ifdef LLC_ARB_STATS_EN
    ,
    output logic [31:0]          stat_l1_grants,
    output logic [31:0]          stat_snp_grants,
    output logic [31:0]          stat_errs
`endif
);

    import llc_req_arbiter_pkg::*;

    localparam int SW = $clog2(MAX_SNOOP_STREAK + 1);

    arb_state_t           state;
    logic [SW-1:0]        streak;
    logic [SW-1:0]        streak_nxt;
    logic                 idle;
    logic                 grant_l1;
    logic                 grant_snp;
    logic                 legal;
    logic                 local_op;
    logic [CMDSIZE-1:0]   cmd_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 src_q;
    logic                 l1_done_q;
    logic                 snp_done_q;
    logic                 err_q;

    // No accept while reset is asserted, so ready must not pulse then.
    assign idle = (state == ST_IDLE) && !rst;

    llc_arb_pick #(
        .MAX_SNOOP_STREAK (MAX_SNOOP_STREAK),
        .SW               (SW)
    ) u_pick (
        .en         (idle),
        .l1_valid   (l1_valid),
        .snp_valid  (snp_valid),
        .streak     (streak),
        .grant_l1   (grant_l1),
        .grant_snp  (grant_snp),
        .streak_nxt (streak_nxt)
    );

    // Snooped writes need no LLC action; they share the local path.
    always_comb begin
        legal    = 1'b1;
        local_op = 1'b0;
        unique case (1'b1)
            grant_snp: begin
                legal    = is_snp_cmd(cmd_bits_t'(snp_cmd));
                local_op = !legal || (cmd_bits_t'(snp_cmd) == SNP_WR);
            end
            grant_l1: begin
                legal    = is_l1_cmd(cmd_bits_t'(l1_cmd));
                local_op = !legal;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            streak     <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            src_q      <= 1'b0;
            l1_done_q  <= 1'b0;
            snp_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            l1_done_q  <= 1'b0;
            snp_done_q <= 1'b0;
            err_q      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_l1 || grant_snp) begin
                        streak <= streak_nxt;
                        cmd_q  <= grant_snp ? snp_cmd : l1_cmd;
                        addr_q <= grant_snp ? snp_addr : l1_addr;
                        src_q  <= grant_snp;
                        if (local_op) begin
                            state      <= ST_LOCAL;
                            l1_done_q  <= grant_l1;
                            snp_done_q <= grant_snp;
                            err_q      <= !legal;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (llc_ready) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (llc_done) begin
                        state      <= ST_IDLE;
                        l1_done_q  <= !src_q;
                        snp_done_q <= src_q;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign l1_ready  = grant_l1;
    assign snp_ready = grant_snp;
    assign l1_done   = l1_done_q;
    assign snp_done  = snp_done_q;
    assign cmd_err   = err_q;
    assign llc_valid = (state == ST_ISSUE);
    assign llc_cmd   = cmd_q;
    assign llc_addr  = addr_q;
    assign llc_src   = src_q;
    assign busy      = (state != ST_IDLE);

`ifdef LLC_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_l1_grants  <= '0;
            stat_snp_grants <= '0;
            stat_errs       <= '0;
        end else begin
            if (grant_l1 && (stat_l1_grants != '1))
                stat_l1_grants <= stat_l1_grants + 32'd1;
            if (grant_snp && (stat_snp_grants != '1))
                stat_snp_grants <= stat_snp_grants + 32'd1;
            if (err_q && (stat_errs != '1))
                stat_errs <= stat_errs + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_llc_req_arbiter.sv
// Randomized and directed bench for llc_req_arbiter against a
// transaction-level reference model.
module tb_llc_req_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        l1_valid, snp_valid;
    logic [3:0]  l1_cmd, snp_cmd;
    logic [31:0] l1_addr, snp_addr;
    logic        l1_ready, l1_done, snp_ready, snp_done;
    logic        llc_valid, llc_src, llc_ready, llc_done;
    logic [3:0]  llc_cmd;
    logic [31:0] llc_addr;
    logic        busy, cmd_err;

    llc_req_arbiter #(
        .MAX_SNOOP_STREAK (MAXS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .l1_valid  (l1_valid),
        .l1_cmd    (l1_cmd),
        .l1_addr   (l1_addr),
        .l1_ready  (l1_ready),
        .l1_done   (l1_done),
        .snp_valid (snp_valid),
        .snp_cmd   (snp_cmd),
        .snp_addr  (snp_addr),
        .snp_ready (snp_ready),
        .snp_done  (snp_done),
        .llc_valid (llc_valid),
        .llc_cmd   (llc_cmd),
        .llc_addr  (llc_addr),
        .llc_src   (llc_src),
        .llc_ready (llc_ready),
        .llc_done  (llc_done),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: one open transaction plus pending pulses
    bit          m_open, m_local, m_sent, m_src;
    bit          p_l1, p_snp, p_err;
    int          m_streak;
    logic [3:0]  m_cmd;
    logic [31:0] m_addr;

    // last sampled outputs, for directed checks
    logic        got_l1, got_snp, s_valid, s_src, s_l1_done;
    logic        s_snp_done, s_err, s_busy;
    logic [3:0]  s_cmd;
    logic [31:0] s_addr;
    logic        seen_valid, seen_err, seen_l1_done, seen_snp_done;
    byte         order_q[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_local = 0; m_sent = 0; m_src = 0;
        p_l1 = 0; p_snp = 0; p_err = 0;
        m_streak = 0; m_cmd = '0; m_addr = '0;
    endtask

    // One clock: check all outputs against the model, advance the model.
    task automatic step();
        bit snp_win, el1, esnp, legal;
        #1;
        snp_win = snp_valid && !(l1_valid && m_streak == MAXS);
        el1  = !rst && !m_open && l1_valid && !snp_win;
        esnp = !rst && !m_open && snp_win;
        check("l1_ready", l1_ready, el1);
        check("snp_ready", snp_ready, esnp);
        check("l1_done", l1_done, p_l1);
        check("snp_done", snp_done, p_snp);
        check("cmd_err", cmd_err, p_err);
        check("busy", busy, m_open);
        check("llc_valid", llc_valid, m_open && !m_local && !m_sent);
        check("llc_cmd", llc_cmd, m_cmd);
        check("llc_addr", llc_addr, m_addr);
        check("llc_src", llc_src, m_src);
        got_l1 = l1_ready; got_snp = snp_ready;
        s_valid = llc_valid; s_cmd = llc_cmd; s_addr = llc_addr;
        s_src = llc_src; s_l1_done = l1_done; s_snp_done = snp_done;
        s_err = cmd_err; s_busy = busy;
        seen_valid |= llc_valid; seen_err |= cmd_err;
        seen_l1_done |= l1_done; seen_snp_done |= snp_done;
        if (l1_ready) order_q.push_back("L");
        if (snp_ready) order_q.push_back("S");
        if (rst) begin
            model_reset();
        end else begin
            p_l1 = 0; p_snp = 0; p_err = 0;
            if (m_open) begin
                if (m_local) m_open = 0;
                else if (!m_sent) m_sent = llc_ready;
                else if (llc_done) begin
                    m_open = 0; p_l1 = !m_src; p_snp = m_src;
                end
            end else if (el1 || esnp) begin
                if (esnp && l1_valid) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
                else m_streak = 0;
                m_src = esnp;
                m_cmd = esnp ? snp_cmd : l1_cmd;
                m_addr = esnp ? snp_addr : l1_addr;
                legal = esnp ? (snp_cmd inside {4'd3, 4'd4, 4'd5, 4'd6})
                             : (l1_cmd inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9});
                m_open = 1; m_sent = 0;
                m_local = !legal || (esnp && snp_cmd == 4'd5);
                if (m_local) begin p_l1 = el1; p_snp = esnp; p_err = !legal; end
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (got_l1) l1_valid = 0;
        if (got_snp) snp_valid = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    task automatic flush();
        l1_valid = 0; snp_valid = 0; llc_ready = 1; llc_done = 1;
        run(4);
        llc_done = 0;
    endtask

    task automatic clear_seen();
        seen_valid = 0; seen_err = 0; seen_l1_done = 0; seen_snp_done = 0;
        order_q.delete();
    endtask

    logic [3:0] l1_pool[5]  = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd9};
    logic [3:0] snp_pool[4] = '{4'd3, 4'd4, 4'd5, 4'd6};
    string      ord;

    initial begin
        rst = 1; l1_valid = 0; snp_valid = 0; l1_cmd = 0; snp_cmd = 0;
        l1_addr = 0; snp_addr = 0; llc_ready = 0; llc_done = 0;
        model_reset(); clear_seen();
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();
        check("rst_busy", s_busy, 1'b0);
        check("rst_llc_valid", s_valid, 1'b0);

        // single L1 read
        l1_valid = 1; l1_cmd = 4'd0; l1_addr = 32'h1000_0040; llc_ready = 1;
        step();
        check("t1_ready_c0", got_l1, 1'b1);
        step();
        check("t1_valid_c1", s_valid, 1'b1);
        check("t1_cmd_c1", s_cmd, 4'd0);
        check("t1_src_c1", s_src, 1'b0);
        check("t1_addr_c1", s_addr, 32'h1000_0040);
        step();
        llc_done = 1; step(); llc_done = 0;
        step();
        check("t1_l1_done", s_l1_done, 1'b1);
        check("t1_busy_after", s_busy, 1'b0);

        // simultaneous requests: snoop first
        clear_seen();
        l1_valid = 1; l1_cmd = 4'd1; l1_addr = 32'h2000;
        snp_valid = 1; snp_cmd = 4'd4; snp_addr = 32'h3000;
        llc_ready = 1; llc_done = 1;
        run(8);
        check("t2_n_grants", order_q.size(), 2);
        if (order_q.size() >= 2) begin
            check("t2_first", order_q[0], "S");
            check("t2_second", order_q[1], "L");
        end
        flush();

        // starvation guard: S,S,S,S,L repeated
        do_reset(); clear_seen();
        llc_ready = 1; llc_done = 1;
        for (int i = 0; i < 60 && order_q.size() < 10; i++) begin
            if (!l1_valid) begin l1_valid = 1; l1_cmd = 4'd1; l1_addr = 32'h40 * i; end
            if (!snp_valid) begin snp_valid = 1; snp_cmd = 4'd6; snp_addr = 32'h80 * i; end
            step();
        end
        ord = "";
        foreach (order_q[i]) if (i < 10) ord = {ord, string'(order_q[i])};
        check("t3_order", ord == "SSSSLSSSSL", 1'b1);
        if (ord != "SSSSLSSSSL") $display("  order seen %s", ord);
        flush();

        // snooped write handled locally
        clear_seen();
        snp_valid = 1; snp_cmd = 4'd5; snp_addr = 32'hABCD;
        run(3);
        check("t4_snpwr_valid", seen_valid, 1'b0);
        check("t4_snpwr_err", seen_err, 1'b0);
        check("t4_snpwr_done", seen_snp_done, 1'b1);
        // misrouted L1 code
        clear_seen();
        l1_valid = 1; l1_cmd = 4'd3; l1_addr = 32'h44;
        run(3);
        check("t4_l1bad_valid", seen_valid, 1'b0);
        check("t4_l1bad_err", seen_err, 1'b1);
        check("t4_l1bad_done", seen_l1_done, 1'b1);

        // LLC stalls: command held stable
        l1_valid = 1; l1_cmd = 4'd2; l1_addr = 32'h5555_AAA0;
        snp_valid = 0; llc_ready = 0; llc_done = 0;
        step();
        snp_valid = 1; snp_cmd = 4'd3; snp_addr = 32'h77;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t5_hold_addr", s_addr, 32'h5555_AAA0);
            check("t5_hold_valid", s_valid, 1'b1);
            check("t5_no_ready", got_snp, 1'b0);
        end
        flush();

        // reset while waiting for LLC completion
        clear_seen();
        l1_valid = 1; l1_cmd = 4'd8; l1_addr = 32'h900; llc_ready = 1; llc_done = 0;
        run(3);
        do_reset();
        llc_done = 1;
        step();
        check("t6_busy", s_busy, 1'b0);
        check("t6_valid", s_valid, 1'b0);
        step();
        check("t6_no_done", s_l1_done, 1'b0);
        llc_done = 0;
        l1_valid = 1; l1_cmd = 4'd9; l1_addr = 32'hBEE0;
        step();
        check("t6_new_accept", got_l1, 1'b1);
        flush();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if (!l1_valid && $urandom_range(0, 2) == 0) begin
                l1_valid = 1; l1_addr = $urandom;
                l1_cmd = ($urandom_range(0, 5) == 0) ? 4'($urandom)
                                                     : l1_pool[$urandom_range(0, 4)];
            end
            if (!snp_valid && $urandom_range(0, 2) == 0) begin
                snp_valid = 1; snp_addr = $urandom;
                snp_cmd = ($urandom_range(0, 5) == 0) ? 4'($urandom)
                                                      : snp_pool[$urandom_range(0, 3)];
            end
            llc_ready = ($urandom_range(0, 1) == 0);
            llc_done  = ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
